shift_exec_stage: RTL
=====================

// Module: shift_exec_stage
// PURPOSE
//  Execute-stage pipeline around the combinational right shifter r_shifter.
//  Decodes RV32I shift ops (SLL/SRL/SRA/SLLI/SRLI/SRAI) and drives r_shifter operands.
//  Left shifts use bit-reversal around the right shifter.
//  Registers the result toward writeback. Both sides use a valid/ready handshake.
//  Sits between decode/regfile read and writeback; r_shifter is instantiated externally.
// PARAMETERS
//  XLEN  32  datapath width
//  SHW   5   shift-amount width, = $clog2(XLEN)
// PORTS
//  clk            in   1     rising-edge clock
//  rst_n          in   1     asynchronous active-low reset
//  in_valid       in   1     upstream op valid
//  in_ready       out  1     stage 1 can accept
//  in_funct3      in   3     001 = SLL*, 101 = SRL*/SRA*
//  in_funct7b5    in   1     1 = arithmetic (SRA/SRAI)
//  in_is_imm      in   1     1 = shamt from in_imm_shamt, 0 = from in_rs2
//  in_rs1         in   XLEN  value to shift
//  in_rs2         in   XLEN  register shift amount (only [SHW-1:0] used)
//  in_imm_shamt   in   SHW+1 immediate shamt field, bit SHW must be 0
//  in_rd          in   5     destination tag, passed through
//  sh_a           out  XLEN  to r_shifter .a
//  sh_b           out  SHW   to r_shifter .b
//  sh_arith       out  1     to r_shifter .arith
//  sh_o           in   XLEN  from r_shifter .o, combinational
//  out_valid      out  1     result valid
//  out_ready      in   1     downstream accepts
//  out_result     out  XLEN  shifted value
//  out_rd         out  5     destination tag
//  out_err        out  1     illegal encoding flag
// BEHAVIOUR
//  - Reset (async, rst_n=0):
//    - s1_valid = s2_valid = 0.
//    - out_result, out_rd, out_err = 0; sh_a, sh_b, sh_arith = 0.
//    - Ops in flight are dropped; none is emitted after release.
//  - Two register stages: S1 (decoded operands) -> r_shifter -> S2 (output regs).
//  - Handshake:
//    - s2_adv = s1_valid && (!s2_valid || out_ready).
//    - in_ready = !s1_valid || s2_adv.
//    - Accept on in_valid && in_ready. S1 loads on accept.
//    - If S1 drains without a new accept, s1_valid <= 0.
//    - S2 loads on s2_adv. If out_ready with no s2_adv, s2_valid <= 0.
//  - Latency: out_valid rises 2 cycles after accept (no stall). Throughput: 1 op/cycle.
//  - Up to 2 ops are buffered under backpressure.
//  - While out_valid && !out_ready, out_result, out_rd and out_err are held stable.
//  - Decode at accept:
//    - left = (funct3==001).
//    - arith = (funct3==101) && funct7b5.
//    - err when any of: funct3 is not 001 or 101; SLL* with funct7b5=1;
//      in_is_imm && in_imm_shamt[SHW]=1.
//  - Operand select: amt = in_is_imm ? in_imm_shamt[SHW-1:0] : in_rs2[SHW-1:0].
//    Upper rs2 bits are ignored.
//  - Shifter drive, when s1_valid:
//    - sh_a = left ? bitrev(s1_rs1) : s1_rs1.
//    - sh_b = s1_amt.
//    - sh_arith = s1_arith; forced to 0 when left.
//    When !s1_valid, sh_a, sh_b and sh_arith are driven 0.
//  - S2 capture:
//    - out_result = s1_err ? 0 : (s1_left ? bitrev(sh_o) : sh_o).
//    - out_err = s1_err.
//    - out_rd = s1_rd.
//  - amt=0 passes rs1 unchanged. amt=31: SRA replicates the sign, SRL leaves bit0=rs1[31].
//  - Simultaneous accept and drain in the same cycle is legal: no bubble, no loss.
// TESTING
//  - SRA, rs1=0x8000_0000, rs2=0xFFFF_FFE4 (amt 4) -> out_result=0xF800_0000;
//    out_valid asserts exactly 2 cycles after accept.
//  - SLLI, rs1=0x0000_0001, shamt=31 -> 0x8000_0000, sh_arith=0.
//    SLL, rs1=0x8000_0001, amt 1 -> 0x0000_0002.
//  - SRL, rs1=0xF000_000F: amt 0 -> 0xF000_000F; amt 31 -> 0x0000_0001.
//    SRAI of the same value, amt 31 -> 0xFFFF_FFFF.
//  - Backpressure: 4 ops issued back-to-back, out_ready=0 for 5 cycles.
//    in_ready drops after 2 accepts; results emerge in order with
//    out_result stable while stalled.
//  - Illegal encodings each give out_err=1, out_result=0, with out_rd passed through:
//    funct3=000; SLLI with funct7b5=1; SRLI with shamt=6'h20.
//  - Assert rst_n=0 with 2 ops in flight -> out_valid=0 and in_ready=1 immediately.
//    No stale result appears after release. Finish with 200 random ops
//    compared against a reference model.

Source files
------------

// File: rtl/shift_exec_stage.sv
// Execute-stage wrapper around an external combinational right shifter.
// Decodes RV32I shifts, drives the shifter from stage 1 and registers results in stage 2.
module shift_exec_stage #(
  parameter int XLEN = 32,
  parameter int SHW  = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_funct3,
  input  logic            in_funct7b5,
  input  logic            in_is_imm,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_rs2,
  input  logic [SHW:0]    in_imm_shamt,
  input  logic [4:0]      in_rd,
  output logic [XLEN-1:0] sh_a,
  output logic [SHW-1:0]  sh_b,
  output logic            sh_arith,
  input  logic [XLEN-1:0] sh_o,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic [4:0]      out_rd,
  output logic            out_err
);

  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_SR  = 3'b101;

  logic            s1_valid_reg;
  logic [XLEN-1:0] s1_rs1_reg;
  logic [SHW-1:0]  s1_amt_reg;
  logic            s1_left_reg;
  logic            s1_arith_reg;
  logic            s1_err_reg;
  logic [4:0]      s1_rd_reg;

  logic            s2_valid_reg;
  logic [XLEN-1:0] out_result_reg;
  logic [4:0]      out_rd_reg;
  logic            out_err_reg;

  logic            s2_adv;
  logic            accept;
  logic            dec_left;
  logic            dec_arith;
  logic            dec_err;
  logic [SHW-1:0]  dec_amt;
  logic [XLEN-1:0] rs1_rev;
  logic [XLEN-1:0] sho_rev;
  logic [XLEN-1:0] out_result_next;
  logic            rs2_hi_unused;

  assign s2_adv   = s1_valid_reg && (!s2_valid_reg || out_ready);
  assign in_ready = !s1_valid_reg || s2_adv;
  assign accept   = in_valid && in_ready;

  // Only the low SHW bits of rs2 form the shift amount.
  assign rs2_hi_unused = ^in_rs2[XLEN-1:SHW];

  always_comb begin
    dec_left  = (in_funct3 == F3_SLL);
    dec_arith = (in_funct3 == F3_SR) && in_funct7b5;
    dec_err   = ((in_funct3 != F3_SLL) && (in_funct3 != F3_SR)) ||
                (dec_left && in_funct7b5) ||
                (in_is_imm && in_imm_shamt[SHW]);
    dec_amt   = in_is_imm ? in_imm_shamt[SHW-1:0] : in_rs2[SHW-1:0];
  end

  // Left shifts reuse the right shifter: reverse bits going in and coming out.
  generate
    for (genvar gi = 0; gi < XLEN; gi++) begin : g_rev
      assign rs1_rev[gi] = s1_rs1_reg[XLEN-1-gi];
      assign sho_rev[gi] = sh_o[XLEN-1-gi];
    end
  endgenerate

  assign sh_a     = s1_valid_reg ? (s1_left_reg ? rs1_rev : s1_rs1_reg) : '0;
  assign sh_b     = s1_valid_reg ? s1_amt_reg : '0;
  assign sh_arith = s1_valid_reg && s1_arith_reg && !s1_left_reg;

  assign out_result_next = s1_err_reg ? '0 : (s1_left_reg ? sho_rev : sh_o);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_reg <= 1'b0;
      s1_rs1_reg   <= '0;
      s1_amt_reg   <= '0;
      s1_left_reg  <= 1'b0;
      s1_arith_reg <= 1'b0;
      s1_err_reg   <= 1'b0;
      s1_rd_reg    <= '0;
    end else if (accept) begin
      s1_valid_reg <= 1'b1;
      s1_rs1_reg   <= in_rs1;
      s1_amt_reg   <= dec_amt;
      s1_left_reg  <= dec_left;
      s1_arith_reg <= dec_arith;
      s1_err_reg   <= dec_err;
      s1_rd_reg    <= in_rd;
    end else if (s2_adv) begin
      s1_valid_reg <= 1'b0;
    end
  end

  // Output registers only change on advance, so they hold while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_reg   <= 1'b0;
      out_result_reg <= '0;
      out_rd_reg     <= '0;
      out_err_reg    <= 1'b0;
    end else if (s2_adv) begin
      s2_valid_reg   <= 1'b1;
      out_result_reg <= out_result_next;
      out_rd_reg     <= s1_rd_reg;
      out_err_reg    <= s1_err_reg;
    end else if (out_ready) begin
      s2_valid_reg   <= 1'b0;
    end
  end

  assign out_valid  = s2_valid_reg;
  assign out_result = out_result_reg;
  assign out_rd     = out_rd_reg;
  assign out_err    = out_err_reg;

endmodule
